// File: rtl/sm3_msg_ctrl_if.sv
// Bundles the message word stream and the compression-core bus of sm3_msg_ctrl.
// The slave view belongs to the controller; the master view belongs to the environment.
interface sm3_msg_ctrl_if;
  logic         i_valid;
  logic [31:0]  i_data;
  logic         i_last;
  logic [2:0]   i_nbytes;
  logic         o_ready;
  logic         o_core_start;
  logic [511:0] o_core_data;
  logic [255:0] o_core_vin;
  logic [255:0] i_core_vout;
  logic         i_core_done;
  logic [255:0] o_hash;
  logic         o_hash_valid;
  logic         o_busy;

  modport slave (
    input  i_valid, i_data, i_last, i_nbytes, i_core_vout, i_core_done,
    output o_ready, o_core_start, o_core_data, o_core_vin, o_hash, o_hash_valid, o_busy
  );

  modport master (
    output i_valid, i_data, i_last, i_nbytes, i_core_vout, i_core_done,
    input  o_ready, o_core_start, o_core_data, o_core_vin, o_hash, o_hash_valid, o_busy
  );
endinterface

// File: rtl/sm3_msg_ctrl.sv
// SM3 message front-end: packs a byte-granular word stream into 512-bit blocks,
// applies SM3 padding and chains each compression result into the next block.
module sm3_msg_ctrl #(
  parameter logic [255:0] IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e
) (
  input  logic          i_clk,
  input  logic          i_rst,
  sm3_msg_ctrl_if.slave bus
);
  localparam logic [2:0] S_FILL = 3'd0;
  localparam logic [2:0] S_HASH = 3'd1;
  localparam logic [2:0] S_PAD  = 3'd2;
  localparam logic [2:0] S_LAST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [0:15][31:0] blk_q, blk_d;
  logic [3:0]        k_q, k_d;
  logic [63:0]       bits_q, bits_d;
  logic [255:0]      chain_q, chain_d;
  logic [255:0]      hash_q, hash_d;
  logic              start_q, start_d;
  logic              hv_q, hv_d;
  logic              busy_q, busy_d;
  logic              pad_q, pad_d;
  logic              carry_q, carry_d;

  logic [31:0] mask, word_m, pad_word;
  logic [63:0] bits_acc;
  logic [4:0]  ppos;

  // Left-justified byte mask; 0x80 goes in the first byte slot after the data.
  assign mask     = ~(32'hFFFF_FFFF >> {bus.i_nbytes, 3'b000});
  assign word_m   = bus.i_data & mask;
  assign pad_word = (bus.i_nbytes >= 3'd4) ? 32'h8000_0000
                                           : (32'h8000_0000 >> {bus.i_nbytes[1:0], 3'b000});
  assign bits_acc = bits_q + {58'd0, bus.i_nbytes, 3'b000};
  assign ppos     = {1'b0, k_q} + {4'd0, (bus.i_nbytes >= 3'd4)};

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    k_d     = k_q;
    bits_d  = bits_q;
    chain_d = chain_q;
    hash_d  = hash_q;
    start_d = 1'b0;
    hv_d    = 1'b0;
    busy_d  = busy_q;
    pad_d   = pad_q;
    carry_d = carry_q;
    case (state_q)
      S_FILL: begin
        if (bus.i_valid) begin
          busy_d     = 1'b1;
          bits_d     = bits_acc;
          blk_d[k_q] = word_m;
          if (bus.i_last) begin
            for (int i = 0; i < 16; i++)
              if (i > int'(k_q)) blk_d[i] = '0;
            if (ppos <= 5'd15) blk_d[ppos[3:0]] = blk_d[ppos[3:0]] | pad_word;
            // Length fits only if the pad byte left words 14..15 free.
            if (ppos <= 5'd13) begin
              blk_d[14] = bits_acc[63:32];
              blk_d[15] = bits_acc[31:0];
              state_d   = S_LAST;
            end else begin
              pad_d   = 1'b1;
              carry_d = (ppos == 5'd16);
              state_d = S_HASH;
            end
            start_d = 1'b1;
            k_d     = '0;
          end else begin
            k_d = k_q + 4'd1;
            if (k_q == 4'd15) begin
              start_d = 1'b1;
              state_d = S_HASH;
            end
          end
        end
      end
      S_HASH: begin
        if (bus.i_core_done) begin
          chain_d = bus.i_core_vout;
          state_d = pad_q ? S_PAD : S_FILL;
        end
      end
      S_PAD: begin
        blk_d     = '0;
        blk_d[0]  = {carry_q, 31'd0};
        blk_d[14] = bits_q[63:32];
        blk_d[15] = bits_q[31:0];
        start_d   = 1'b1;
        pad_d     = 1'b0;
        carry_d   = 1'b0;
        state_d   = S_LAST;
      end
      S_LAST: begin
        if (bus.i_core_done) begin
          chain_d = bus.i_core_vout;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        hash_d  = chain_q;
        hv_d    = 1'b1;
        chain_d = IV;
        bits_d  = '0;
        k_d     = '0;
        busy_d  = 1'b0;
        state_d = S_FILL;
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_FILL;
      blk_q   <= '0;
      k_q     <= '0;
      bits_q  <= '0;
      chain_q <= IV;
      hash_q  <= '0;
      start_q <= 1'b0;
      hv_q    <= 1'b0;
      busy_q  <= 1'b0;
      pad_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      k_q     <= k_d;
      bits_q  <= bits_d;
      chain_q <= chain_d;
      hash_q  <= hash_d;
      start_q <= start_d;
      hv_q    <= hv_d;
      busy_q  <= busy_d;
      pad_q   <= pad_d;
      carry_q <= carry_d;
    end
  end

  assign bus.o_ready      = (state_q == S_FILL);
  assign bus.o_core_start = start_q;
  assign bus.o_core_data  = blk_q;
  assign bus.o_core_vin   = chain_q;
  assign bus.o_hash       = hash_q;
  assign bus.o_hash_valid = hv_q;
  assign bus.o_busy       = busy_q;
endmodule

// File: tb/tb_sm3_msg_ctrl.sv
// Bench for sm3_msg_ctrl: a reference SM3 core answers start pulses, and a byte-level
// padding/compression model predicts every block, chaining value and digest.
module tb_sm3_msg_ctrl;
  localparam logic [255:0] IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
  localparam logic [255:0] D_ABC   = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
  localparam logic [255:0] D_ABCD  = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;
  localparam logic [255:0] D_EMPTY = 256'h1ab21d83_55cfa17f_8e611948_31e81a8f_22bec8c7_28fefb74_7ed035eb_5082aa2b;
  localparam int CORE_LAT = 64;

  logic i_clk, i_rst;
  sm3_msg_ctrl_if bus();
  sm3_msg_ctrl #(.IV(IV)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  int n_chk = 0, n_fail = 0, n_hv = 0, n_start = 0;
  int stale_req_n = 0, stale_done_n = 0;
  logic [511:0] exp_blk[$];
  logic [255:0] exp_dig[$];
  logic [7:0]   mbuf[0:255];

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic flag_fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got no event, want event", nm);
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    int s = n % 32;
    return (s == 0) ? x : ((x << s) | (x >> (32 - s)));
  endfunction
  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl(x, 9) ^ rotl(x, 17);
  endfunction
  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  function automatic logic [255:0] sm3_cf(input logic [255:0] v, input logic [511:0] blk);
    logic [31:0] w [0:67];
    logic [31:0] w1[0:63];
    logic [31:0] a, b, c, d, e, f, g, h, ss1, ss2, tt1, tt2, t;
    for (int j = 0; j < 16; j++) w[j] = blk[511-32*j -: 32];
    for (int j = 16; j < 68; j++)
      w[j] = p1(w[j-16] ^ w[j-9] ^ rotl(w[j-3], 15)) ^ rotl(w[j-13], 7) ^ w[j-6];
    for (int j = 0; j < 64; j++) w1[j] = w[j] ^ w[j+4];
    {a, b, c, d, e, f, g, h} = v;
    for (int j = 0; j < 64; j++) begin
      t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
      ss1 = rotl(rotl(a, 12) + e + rotl(t, j), 7);
      ss2 = ss1 ^ rotl(a, 12);
      tt1 = ((j < 16) ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c))) + d + ss2 + w1[j];
      tt2 = ((j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g))) + h + ss1 + w[j];
      d = c; c = rotl(b, 9); b = a; a = tt1;
      h = g; g = rotl(f, 19); f = e; e = p0(tt2);
    end
    return {a, b, c, d, e, f, g, h} ^ v;
  endfunction

  // Textbook padding on a byte array, then queue the blocks and the digest.
  task automatic model_push(input int len, output int nb, output logic [511:0] lastblk);
    logic [7:0]   pb[0:255];
    int           plen;
    logic [63:0]  bl;
    logic [255:0] v;
    logic [511:0] blk;
    for (int i = 0; i < len; i++) pb[i] = mbuf[i];
    pb[len] = 8'h80;
    plen = len + 1;
    while (plen % 64 != 56) begin pb[plen] = 8'h00; plen++; end
    bl = 64'(len) * 64'd8;
    for (int i = 0; i < 8; i++) begin pb[plen] = bl[63-8*i -: 8]; plen++; end
    nb = plen / 64;
    v = IV;
    lastblk = '0;
    for (int b = 0; b < nb; b++) begin
      blk = '0;
      for (int i = 0; i < 64; i++) blk = {blk[503:0], pb[64*b+i]};
      exp_blk.push_back(blk);
      v = sm3_cf(v, blk);
      lastblk = blk;
    end
    exp_dig.push_back(v);
  endtask

  task automatic send_msg(input int len, output int stalls);
    int nw, nbt, guard;
    logic [31:0] wd;
    nw = (len == 0) ? 1 : (len + 3) / 4;
    stalls = 0;
    for (int w = 0; w < nw; w++) begin
      @(negedge i_clk);
      nbt = (w == nw - 1) ? len - 4 * w : 4;
      wd = '0;
      for (int b = 0; b < 4; b++) wd = {wd[23:0], (b < nbt) ? mbuf[4*w+b] : 8'hA5};
      bus.i_valid  = 1'b1;
      bus.i_data   = wd;
      bus.i_last   = (w == nw - 1);
      bus.i_nbytes = 3'(nbt);
      guard = 0;
      while (!bus.o_ready && guard < 1000) begin
        @(negedge i_clk);
        stalls++;
        guard++;
      end
      if (guard >= 1000) flag_fail("word accept timeout");
    end
    @(negedge i_clk);
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    bus.i_data  = $urandom;
  endtask

  task automatic wait_hv(input int tgt);
    int g = 0;
    while (n_hv < tgt && g < 5000) begin @(negedge i_clk); g++; end
    if (n_hv < tgt) flag_fail("hash_valid timeout");
  endtask

  // Reference core plus the per-cycle compare against the model.
  initial begin
    int cnt;
    logic [511:0] c_blk, eb;
    logic [255:0] c_vin, c_res, mchain, last_hash;
    cnt = -1; mchain = IV; last_hash = '0; eb = '0;
    bus.i_core_done = 1'b0;
    bus.i_core_vout = '0;
    forever begin
      @(negedge i_clk);
      bus.i_core_done = 1'b0;
      if (i_rst) begin
        cnt = -1; mchain = IV; last_hash = '0;
      end else begin
        if (bus.o_core_start) begin
          n_start++;
          if (cnt >= 0) flag_fail("start while core busy");
          c_blk = bus.o_core_data;
          c_vin = bus.o_core_vin;
          c_res = sm3_cf(c_vin, c_blk);
          cnt = CORE_LAT;
          if (exp_blk.size() == 0) flag_fail("unexpected block start");
          else begin
            eb = exp_blk.pop_front();
            chk("core_data", bus.o_core_data, eb);
          end
          chk("core_vin", 512'(bus.o_core_vin), 512'(mchain));
          mchain = sm3_cf(mchain, eb);
        end else if (cnt > 0) begin
          chk("ready low while hashing", 512'(bus.o_ready), 512'(0));
          cnt--;
          if (cnt == 0) begin
            chk("core_data held", bus.o_core_data, c_blk);
            chk("core_vin held", 512'(bus.o_core_vin), 512'(c_vin));
            bus.i_core_vout = c_res;
            bus.i_core_done = 1'b1;
            cnt = -1;
          end
        end else if (stale_req_n != stale_done_n) begin
          bus.i_core_vout = {8{32'hdeadbeef}};
          bus.i_core_done = 1'b1;
          stale_done_n++;
        end
        if (bus.o_hash_valid) begin
          if (exp_dig.size() == 0) flag_fail("unexpected hash_valid");
          else chk("digest", 512'(bus.o_hash), 512'(exp_dig.pop_front()));
          chk("busy low at hash_valid", 512'(bus.o_busy), 512'(0));
          last_hash = bus.o_hash;
          mchain = IV;
          n_hv++;
        end else begin
          chk("hash held", 512'(bus.o_hash), 512'(last_hash));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, st, h0, s0;
    logic [511:0] lb;
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_last = 1'b0; bus.i_nbytes = '0;
    i_rst = 1'b0;
    #1 i_rst = 1'b1;
    #1;
    chk("rst ready", 512'(bus.o_ready), 512'(1));
    chk("rst start", 512'(bus.o_core_start), 512'(0));
    chk("rst hash", 512'(bus.o_hash), 512'(0));
    chk("rst hash_valid", 512'(bus.o_hash_valid), 512'(0));
    chk("rst busy", 512'(bus.o_busy), 512'(0));
    chk("rst vin", 512'(bus.o_core_vin), 512'(IV));
    chk("rst data", bus.o_core_data, 512'(0));
    @(negedge i_clk); @(negedge i_clk); #2 i_rst = 1'b0;

    // "abc"
    mbuf[0] = 8'h61; mbuf[1] = 8'h62; mbuf[2] = 8'h63;
    model_push(3, nb, lb);
    chk("abc nblk", 512'(nb), 512'(1));
    chk("abc block", lb, {32'h61626380, 416'h0, 32'h0, 32'h18});
    h0 = n_hv;
    send_msg(3, st);
    chk("busy during hash", 512'(bus.o_busy), 512'(1));
    wait_hv(h0 + 1);
    chk("abc digest", 512'(bus.o_hash), 512'(D_ABC));

    // "abcd" x16: pad byte carries into a second block
    for (int i = 0; i < 64; i++) mbuf[i] = 8'h61 + 8'(i % 4);
    s0 = n_start;
    model_push(64, nb, lb);
    chk("abcd16 nblk", 512'(nb), 512'(2));
    chk("abcd16 pad block", lb, {32'h80000000, 416'h0, 64'h200});
    h0 = n_hv;
    send_msg(64, st);
    wait_hv(h0 + 1);
    chk("abcd16 digest", 512'(bus.o_hash), 512'(D_ABCD));
    chk("abcd16 starts", 512'(n_start - s0), 512'(2));

    // empty message
    s0 = n_start;
    model_push(0, nb, lb);
    chk("empty block", lb, {32'h80000000, 480'h0});
    h0 = n_hv;
    send_msg(0, st);
    wait_hv(h0 + 1);
    chk("empty digest", 512'(bus.o_hash), 512'(D_EMPTY));
    chk("empty starts", 512'(n_start - s0), 512'(1));

    // 55 vs 56 bytes: one block vs two
    for (int i = 0; i < 256; i++) mbuf[i] = 8'(i * 7 + 3);
    s0 = n_start;
    model_push(55, nb, lb);
    chk("len55 word", 512'(lb[31:0]), 512'(32'h1B8));
    h0 = n_hv;
    send_msg(55, st);
    wait_hv(h0 + 1);
    chk("len55 starts", 512'(n_start - s0), 512'(1));
    s0 = n_start;
    model_push(56, nb, lb);
    chk("len56 word", 512'(lb[63:0]), 512'(64'h1C0));
    h0 = n_hv;
    send_msg(56, st);
    wait_hv(h0 + 1);
    chk("len56 starts", 512'(n_start - s0), 512'(2));

    // 80 bytes then "abc" back to back, words held while the core runs
    h0 = n_hv;
    model_push(80, nb, lb);
    send_msg(80, st);
    chk("stall during hash", 512'(st >= 60), 512'(1));
    mbuf[0] = 8'h61; mbuf[1] = 8'h62; mbuf[2] = 8'h63;
    model_push(3, nb, lb);
    send_msg(3, st);
    wait_hv(h0 + 2);
    chk("b2b abc digest", 512'(bus.o_hash), 512'(D_ABC));

    // reset mid-hash, stale done, then a clean "abc"
    model_push(3, nb, lb);
    h0 = n_hv;
    send_msg(3, st);
    repeat (20) @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    chk("midrst ready", 512'(bus.o_ready), 512'(1));
    chk("midrst busy", 512'(bus.o_busy), 512'(0));
    chk("midrst hash", 512'(bus.o_hash), 512'(0));
    chk("midrst start", 512'(bus.o_core_start), 512'(0));
    chk("midrst vin", 512'(bus.o_core_vin), 512'(IV));
    exp_blk.delete();
    exp_dig.delete();
    @(negedge i_clk); @(negedge i_clk); #2 i_rst = 1'b0;
    stale_req_n++;
    repeat (4) @(negedge i_clk);
    chk("no digest after abort", 512'(n_hv), 512'(h0));
    chk("hash zero after stale done", 512'(bus.o_hash), 512'(0));
    model_push(3, nb, lb);
    h0 = n_hv;
    send_msg(3, st);
    wait_hv(h0 + 1);
    chk("post-reset abc digest", 512'(bus.o_hash), 512'(D_ABC));

    repeat (3) @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
